// File: rtl/tilemap_pkg.sv
// Shared tile-map geometry defaults and draw-sequencer state encoding.
// Used by the map walker, the scene controller and the drawer bench.
package tilemap_pkg;

  localparam int MAP_COLS = 20;
  localparam int MAP_ROWS = 15;
  localparam int TILE_W   = 8;
  localparam int TILE_H   = 8;
  localparam int MAP_AW   = 9;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_LATCH     = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_ACK  = 3'd4,
    ST_WAIT_DONE = 3'd5,
    ST_NEXT      = 3'd6,
    ST_FINISH    = 3'd7
  } tile_state_e;

endpackage

// File: rtl/tile_cell_counter.sv
// Raster-order column/row counter over the tile map with last-cell flag.
// The linear address is kept as its own counter so no multiplier is needed.
module tile_cell_counter
  import tilemap_pkg::*;
#(
  parameter int CNT_COLS = 20,
  parameter int CNT_ROWS = 15,
  parameter int CNT_AW   = 9,
  parameter int COL_W    = $clog2(CNT_COLS),
  parameter int ROW_W    = $clog2(CNT_ROWS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              advance_i,
  output logic [COL_W-1:0]  col_o,
  output logic [ROW_W-1:0]  row_o,
  output logic [CNT_AW-1:0] addr_o,
  output logic              last_o
);

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [CNT_AW-1:0] addr_q, addr_d;
  logic              col_end;

  assign col_end = (col_q == COL_W'(CNT_COLS - 1));
  assign last_o  = col_end && (row_q == ROW_W'(CNT_ROWS - 1));

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    // Advancing past the last cell wraps to the origin so the counter never leaves the map.
    if (clear_i || (advance_i && last_o)) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (advance_i) begin
      addr_d = addr_q + CNT_AW'(1);
      if (col_end) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/draw_tilemap.sv
// Tile-map draw initiator: walks the map and issues one drawer request per cell.
// Build option SKIP_EMPTY_TILE_EN: cells holding tile index 0 are skipped, not drawn.
module draw_tilemap
  import tilemap_pkg::*;
#(
  parameter int MAP_COLS = tilemap_pkg::MAP_COLS,
  parameter int MAP_ROWS = tilemap_pkg::MAP_ROWS,
  parameter int TILE_W   = tilemap_pkg::TILE_W,
  parameter int TILE_H   = tilemap_pkg::TILE_H,
  parameter int MAP_AW   = tilemap_pkg::MAP_AW
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  output logic [MAP_AW-1:0] MapAddress,
  input  logic [3:0]        MapData,
  output logic [7:0]        TileX,
  output logic [6:0]        TileY,
  output logic [3:0]        TileSel,
  output logic              TileEnable,
  input  logic              TileDone,
  output logic              Busy,
  output logic              Done
);

  localparam int COL_W = $clog2(MAP_COLS);
  localparam int ROW_W = $clog2(MAP_ROWS);

  tile_state_e      state_q;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             last_cell;
  logic             cnt_clear;
  logic             cnt_advance;
  logic             skip_cell;
  logic [7:0]       tile_x_q;
  logic [6:0]       tile_y_q;
  logic [3:0]       tile_sel_q;
  logic             tile_en_q;
  logic             busy_q;
  logic             done_q;

  assign cnt_clear   = (state_q == ST_IDLE) && Start;
  assign cnt_advance = (state_q == ST_NEXT);

`ifdef SKIP_EMPTY_TILE_EN
  assign skip_cell = (MapData == 4'd0);
`else
  assign skip_cell = 1'b0;
`endif

  tile_cell_counter #(
    .CNT_COLS (MAP_COLS),
    .CNT_ROWS (MAP_ROWS),
    .CNT_AW   (MAP_AW)
  ) u_counter (
    .clk_i     (Clock),
    .rst_i     (Reset),
    .clear_i   (cnt_clear),
    .advance_i (cnt_advance),
    .col_o     (col),
    .row_o     (row),
    .addr_o    (MapAddress),
    .last_o    (last_cell)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      tile_x_q   <= '0;
      tile_y_q   <= '0;
      tile_sel_q <= '0;
      tile_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tile_en_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            state_q <= ST_FETCH;
            busy_q  <= 1'b1;
          end
        end
        ST_FETCH: state_q <= ST_LATCH;
        ST_LATCH: begin
          if (skip_cell) begin
            state_q <= ST_NEXT;
          end else begin
            tile_sel_q <= MapData;
            tile_x_q   <= 8'(col * TILE_W);
            tile_y_q   <= 7'(row * TILE_H);
            state_q    <= ST_ISSUE;
          end
        end
        // Only request when the drawer reports idle; otherwise keep waiting here.
        ST_ISSUE: begin
          if (TileDone) begin
            tile_en_q <= 1'b1;
            state_q   <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK:  if (!TileDone) state_q <= ST_WAIT_DONE;
        ST_WAIT_DONE: if (TileDone)  state_q <= ST_NEXT;
        ST_NEXT: begin
          if (last_cell) begin
            state_q <= ST_FINISH;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_FETCH;
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign TileX      = tile_x_q;
  assign TileY      = tile_y_q;
  assign TileSel    = tile_sel_q;
  assign TileEnable = tile_en_q;
  assign Busy       = busy_q;
  assign Done       = done_q;

endmodule
